regfile_alu_core: RTL and testbench
===================================

Name: regfile_alu_core

Overview:
- Datapath core made of a 16-entry x 32-bit register bank (two combinational read ports, one synchronous write port) feeding a combinational 8-operation ALU.
- A writeback mux selects either external write data or the ALU result for the register write.
- Sits between instruction decode/control and the rest of the RISC pipeline.

Parameters:
- DATA_W, 32, register and ALU data width.
- ADDR_W, 4, register address width; register count = 2**ADDR_W (16).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- read_reg1  input  ADDR_W  source register A address.
- read_reg2  input  ADDR_W  source register B address.
- write_reg  input  ADDR_W  destination register address.
- write_data  input  DATA_W  external write data.
- write_enable  input  1  register write enable.
- wb_sel  input  1  writeback source: 0 = write_data, 1 = alu_result.
- opcode  input  4  ALU operation select.
- data_out1  output  DATA_W  contents of register read_reg1 (ALU operand A).
- data_out2  output  DATA_W  contents of register read_reg2 (ALU operand B).
- alu_result  output  DATA_W  ALU result.
- zero  output  1  high when alu_result == 0.

Behaviour:
- Reset: on a rising clk edge with rst=1, register[i] loads i (R0=0, R1=1 ... R9=9 ... R15=15). rst has priority over write_enable.
- Write: on a rising edge with rst=0 and write_enable=1, register[write_reg] <= (wb_sel ? alu_result : write_data). One-cycle latency: the new value is visible on the read ports after that edge.
- R0 is an ordinary writable register (not hardwired to zero).
- Reads are purely combinational with no write bypass; a read of the register being written in the same cycle returns the old value.
- Read-modify-write of one register in a single cycle is legal: operands are sampled before the edge and the result is written at the edge.
- The ALU is purely combinational (A = data_out1, B = data_out2), so alu_result and zero respond in the same cycle as address or opcode changes.
- Opcodes:
  - 0000 ADD: A+B, modulo 2^32, carry discarded.
  - 0001 SUB: A-B, two's complement, wraps.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SL: A << B[4:0], zero fill.
  - 0110 SRL: A >> B[4:0], zero fill.
  - 0111 SRA: A >>> B[4:0], sign fill from A[31].
  - 1000-1111 reserved: alu_result = 0 (so zero=1).
- Shift amount uses only B[4:0]; B[31:5] is ignored. A shift by 0 returns A unchanged.
- No flags beyond zero; overflow and carry are not reported.
- Outputs are not registered. data_out1/2 reflect register contents, which are defined once the first reset has been applied.

Decomposition:
- Shared package regfile_alu_pkg holds:
  - DATA_W and ADDR_W defaults.
  - Opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SL, OP_SRL, OP_SRA.
- Sub-modules:
  - register_bank: storage, reset init, write port, two read ports.
  - alu: combinational operations plus zero flag.
- Top regfile_alu_core instantiates both and contains only the writeback mux.

Test Plan:
- Reset: assert rst for 1 edge, read_reg1=1, read_reg2=9 -> data_out1=1, data_out2=9; all R0..R15 equal their index.
- External write: write_reg=3, write_data=100, write_enable=1, wb_sel=0, one edge -> R3=100 after the edge; before the edge a read of R3 shows 3 (no bypass).
- ALU writeback chain with wb_sel=1, write_enable=1, opcode=ADD:
  - R1+R9 -> R3: alu_result=10, R3=10.
  - R1+R3 -> R2: R2=11.
  - R2+R9 -> R2 (same source/destination): R2=20 after the edge.
- Operation sweep:
  - Load R4=0x80000000, R5=4, read A=R4, B=R5: SL=0x00000000 (zero=1), SRL=0x08000000, SRA=0xF8000000, AND=0, OR=0x80000004, XOR=0x80000004.
  - SUB R1-R9 = 0xFFFFFFF8.
  - Opcode 1010 -> 0.
- Shift masking: B=0x00000021, A=0x00000001, SL -> 0x00000002 (only B[4:0]=1 used).
- Reset priority: rst=1 and write_enable=1 on the same edge targeting R3 with data 0xDEADBEEF -> R3=3 after the edge.

Source files
------------

// File: rtl/regfile_alu_pkg.sv
// Shared definitions for the register-bank + ALU datapath core.
// Holds the default data/address widths and the ALU opcode encodings.
package regfile_alu_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned OP_W       = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_SL  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SRL = 4'b0110;
    localparam logic [OP_W-1:0] OP_SRA = 4'b0111;

endpackage

// File: rtl/alu.sv
// Combinational 8-operation ALU with zero flag.
// Ports:
//   a, b       - operands
//   opcode     - operation select (upper half of the encoding space yields 0)
//   result     - operation result
//   zero       - high when result is all zeros
module alu
    import regfile_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    // Shifts only look at the low bits of b; the rest is deliberately ignored.
    logic [SHAMT_W-1:0] shamt;
    logic               unused_b_hi;

    assign shamt       = b[SHAMT_W-1:0];
    assign unused_b_hi = ^b[DATA_W-1:SHAMT_W];

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SL:   result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/register_bank.sv
// Register bank: 2**ADDR_W entries of DATA_W bits.
// Ports:
//   clk, rst          - clock, synchronous active-high reset (entry i loads i)
//   read_reg1/2       - combinational read addresses
//   data_out1/2       - read data, no write bypass
//   write_reg/data    - synchronous write port, qualified by write_enable
module register_bank
    import regfile_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_enable,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (write_enable) begin
            regs[write_reg] <= write_data;
        end
    end

    assign data_out1 = regs[read_reg1];
    assign data_out2 = regs[read_reg2];

endmodule

// File: rtl/regfile_alu_core.sv
// Datapath core: register bank feeding the ALU, with a writeback mux
// choosing external data (wb_sel=0) or the ALU result (wb_sel=1).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   read_reg1/2, data_out1/2  - register read ports (ALU operands A/B)
//   write_reg, write_data,
//   write_enable, wb_sel      - register write port and source select
//   opcode, alu_result, zero  - ALU control and outputs
module regfile_alu_core
    import regfile_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_enable,
    input  logic              wb_sel,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero
);

    logic [DATA_W-1:0] wb_data;

    assign wb_data = wb_sel ? alu_result : write_data;

    register_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_register_bank (
        .clk          (clk),
        .rst          (rst),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .write_reg    (write_reg),
        .write_data   (wb_data),
        .write_enable (write_enable),
        .data_out1    (data_out1),
        .data_out2    (data_out2)
    );

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (data_out1),
        .b      (data_out2),
        .opcode (opcode),
        .result (alu_result),
        .zero   (zero)
    );

endmodule

// File: tb/tb_regfile_alu_core.sv
module tb_regfile_alu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] write_data;
    logic        write_enable, wb_sel;
    logic [3:0]  opcode;
    logic [31:0] data_out1, data_out2, alu_result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_regs [16];
    logic        model_valid = 1'b0;

    regfile_alu_core dut (
        .clk          (clk),
        .rst          (rst),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_enable (write_enable),
        .wb_sel       (wb_sel),
        .opcode       (opcode),
        .data_out1    (data_out1),
        .data_out2    (data_out2),
        .alu_result   (alu_result),
        .zero         (zero)
    );

    initial forever #5 clk = ~clk;

    // Reference ALU from plain arithmetic.
    function automatic logic [31:0] model_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned sh;
        logic [63:0] ext;
        logic [63:0] prod;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a + ~b + 32'd1;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: begin
                prod = {32'd0, a} * (64'd1 << sh);
                return prod[31:0];
            end
            4'd6: return a / (32'd1 << sh);
            4'd7: begin
                ext = {{32{a[31]}}, a};
                ext = ext >> sh;
                return ext[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model register state; inputs are stable across each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) model_regs[i] = 32'(i);
            model_valid = 1'b1;
        end else if (write_enable && model_valid) begin
            model_regs[write_reg] = wb_sel
                ? model_alu(opcode, model_regs[read_reg1], model_regs[read_reg2])
                : write_data;
        end
    end

    // Continuous compare against the model.
    always @(negedge clk) begin
        logic [31:0] exp_alu;
        if (model_valid) begin
            exp_alu = model_alu(opcode, model_regs[read_reg1], model_regs[read_reg2]);
            check("cmp_data_out1", data_out1, model_regs[read_reg1]);
            check("cmp_data_out2", data_out2, model_regs[read_reg2]);
            check("cmp_alu_result", alu_result, exp_alu);
            check("cmp_zero", {31'd0, zero}, {31'd0, exp_alu == 32'd0});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] wr,
                       input logic [31:0] wd, input logic we, input logic ws,
                       input logic [3:0] op, input logic rs);
        read_reg1 = r1; read_reg2 = r2; write_reg = wr; write_data = wd;
        write_enable = we; wb_sel = ws; opcode = op; rst = rs;
    endtask

    initial begin
        set(4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        tick();

        // Reset values
        set(4'd1, 4'd9, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        check("reset_r1", data_out1, 32'd1);
        check("reset_r9", data_out2, 32'd9);
        for (int i = 0; i < 16; i++) begin
            read_reg1 = 4'(i);
            #1;
            check("reset_all", data_out1, 32'(i));
        end

        // External write, no bypass
        tick();
        set(4'd3, 4'd0, 4'd3, 32'd100, 1'b1, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        check("no_bypass_r3", data_out1, 32'd3);
        tick();
        write_enable = 1'b0;
        #1;
        check("ext_write_r3", data_out1, 32'd100);

        // ALU writeback chain
        set(4'd1, 4'd9, 4'd3, 32'd0, 1'b1, 1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        check("chain_add1", alu_result, 32'd10);
        tick();
        set(4'd1, 4'd3, 4'd2, 32'd0, 1'b1, 1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        check("chain_r3", data_out2, 32'd10);
        check("chain_add2", alu_result, 32'd11);
        tick();
        set(4'd2, 4'd9, 4'd2, 32'd0, 1'b1, 1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        check("chain_r2_old", data_out1, 32'd11);
        check("chain_add3", alu_result, 32'd20);
        tick();
        write_enable = 1'b0;
        #1;
        check("chain_r2_new", data_out1, 32'd20);

        // Operation sweep on R4=0x80000000, R5=4
        set(4'd0, 4'd0, 4'd4, 32'h8000_0000, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        set(4'd0, 4'd0, 4'd5, 32'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        set(4'd4, 4'd5, 4'd0, 32'd0, 1'b0, 1'b0, 4'b0101, 1'b0);
        #1;
        check("sweep_sl", alu_result, 32'h0000_0000);
        check("sweep_sl_zero", {31'd0, zero}, 32'd1);
        opcode = 4'b0110; #1; check("sweep_srl", alu_result, 32'h0800_0000);
        opcode = 4'b0111; #1; check("sweep_sra", alu_result, 32'hF800_0000);
        opcode = 4'b0010; #1; check("sweep_and", alu_result, 32'h0000_0000);
        opcode = 4'b0011; #1; check("sweep_or", alu_result, 32'h8000_0004);
        opcode = 4'b0100; #1; check("sweep_xor", alu_result, 32'h8000_0004);
        check("sweep_xor_zero", {31'd0, zero}, 32'd0);
        read_reg1 = 4'd1; read_reg2 = 4'd9; opcode = 4'b0001; #1;
        check("sweep_sub", alu_result, 32'hFFFF_FFF8);
        opcode = 4'b1010; #1;
        check("reserved_op", alu_result, 32'd0);
        check("reserved_zero", {31'd0, zero}, 32'd1);

        // Shift amount masking
        tick();
        set(4'd0, 4'd0, 4'd6, 32'h0000_0021, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        set(4'd1, 4'd6, 4'd0, 32'd0, 1'b0, 1'b0, 4'b0101, 1'b0);
        #1;
        check("shift_mask", alu_result, 32'h0000_0002);

        // Reset priority over write
        tick();
        set(4'd3, 4'd2, 4'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'd0, 1'b1);
        tick();
        set(4'd3, 4'd2, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        #1;
        check("rst_prio_r3", data_out1, 32'd3);
        check("rst_prio_r2", data_out2, 32'd2);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            tick();
            read_reg1    = 4'($urandom_range(0, 15));
            read_reg2    = 4'($urandom_range(0, 15));
            write_reg    = 4'($urandom_range(0, 15));
            write_data   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            write_enable = ($urandom_range(0, 3) != 0);
            wb_sel       = $urandom_range(0, 1) == 1;
            opcode       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15))
                                                       : 4'($urandom_range(0, 7));
            rst          = ($urandom_range(0, 99) == 0);
        end
        tick();
        rst = 1'b0;
        write_enable = 1'b0;
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
